mem_ctrl: RTL and testbench

- CPU-side initiator of the byte-serial memory bus.
- Accepts word instruction-fetch requests and byte/half/word load/store requests.
- Serializes each request into little-endian single-byte accesses on mem_a/mem_wr/mem_dout/mem_din.
- Responds with a one-cycle done pulse. Sits inside cpu, between the fetch unit / load-store buffer and the top-level RAM/IO bus.

---
 rtl/cpu_defs.sv | 42 ++++
 rtl/mem_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: access-size encoding, memory-controller states and
// small byte-lane helpers used by the byte-serial bus initiator.
package cpu_defs;

    localparam logic [1:0] IO_HI_DEF = 2'b11;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef logic [1:0] mc_state_t;
    localparam mc_state_t ST_IDLE  = 2'd0;
    localparam mc_state_t ST_READ  = 2'd1;
    localparam mc_state_t ST_WRITE = 2'd2;

    function automatic logic is_io(input logic [31:0] addr,
                                   input logic [1:0]  io_hi = IO_HI_DEF);
        return addr[17:16] == io_hi;
    endfunction

    // The illegal size encoding 3 is handled as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory bus initiator: turns word fetches and byte/half/word
// loads and stores into little-endian single-byte accesses with a done pulse.
module mem_ctrl
    import cpu_defs::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush
);

    mc_state_t   state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [2:0]  iss_q, iss_d;
    logic [2:0]  cap_q, cap_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fetch_q, fetch_d;
    logic        p1_q, p1_d;
    logic        p2_q, p2_d;
    logic        replay_q, replay_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic ls_go;
    logic if_go;
    logic last_cap;

    assign ls_go    = ls_req && !(ls_we && is_io(ls_addr, IO_HI) && io_buffer_full);
    assign if_go    = if_req && !flush;
    // p1 marks an address on mem_a this cycle, p2 marks mem_din returning one.
    assign last_cap = p2_q && ((cap_q + 3'd1) == nbytes_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nbytes_d   = nbytes_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        wdata_d    = wdata_q;
        fetch_d    = fetch_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        replay_d   = replay_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;

        if (!rdy_in) begin
            if (state_q == ST_READ) begin
                replay_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ls_go) begin
                        base_d   = ls_addr;
                        nbytes_d = size_bytes(ls_size);
                        wdata_d  = ls_wdata;
                        fetch_d  = 1'b0;
                        mem_a_d  = ls_addr;
                        iss_d    = 3'd1;
                        cap_d    = 3'd0;
                        asm_d    = 32'h0;
                        if (ls_we) begin
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                            state_d    = ST_WRITE;
                        end else begin
                            p1_d    = 1'b1;
                            p2_d    = 1'b0;
                            state_d = ST_READ;
                        end
                    end else if (if_go) begin
                        base_d   = if_addr;
                        nbytes_d = 3'd4;
                        fetch_d  = 1'b1;
                        mem_a_d  = if_addr;
                        iss_d    = 3'd1;
                        cap_d    = 3'd0;
                        asm_d    = 32'h0;
                        p1_d     = 1'b1;
                        p2_d     = 1'b0;
                        state_d  = ST_READ;
                    end
                end

                ST_WRITE: begin
                    if (iss_q == nbytes_q) begin
                        mem_wr_d  = 1'b0;
                        mem_a_d   = 32'h0;
                        ls_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        mem_a_d    = base_q + {29'b0, iss_q};
                        mem_dout_d = byte_sel(wdata_q, iss_q[1:0]);
                        iss_d      = iss_q + 3'd1;
                    end
                end

                ST_READ: begin
                    if (fetch_q && flush) begin
                        mem_a_d  = 32'h0;
                        p1_d     = 1'b0;
                        p2_d     = 1'b0;
                        replay_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (replay_q) begin
                        // The RAM kept sampling a stale address during the pause:
                        // restart from the first byte not yet captured.
                        mem_a_d  = base_q + {29'b0, cap_q};
                        iss_d    = cap_q + 3'd1;
                        p1_d     = 1'b1;
                        p2_d     = 1'b0;
                        replay_d = 1'b0;
                    end else begin
                        if (p2_q) begin
                            asm_d = byte_put(asm_q, cap_q[1:0], mem_din);
                            cap_d = cap_q + 3'd1;
                        end
                        p2_d = p1_q;
                        if (iss_q < nbytes_q) begin
                            mem_a_d = base_q + {29'b0, iss_q};
                            iss_d   = iss_q + 3'd1;
                            p1_d    = 1'b1;
                        end else begin
                            p1_d = 1'b0;
                        end
                        if (last_cap) begin
                            mem_a_d = 32'h0;
                            p1_d    = 1'b0;
                            p2_d    = 1'b0;
                            state_d = ST_IDLE;
                            if (fetch_q) begin
                                if_done_d = 1'b1;
                                if_data_d = asm_d;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = asm_d;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            base_q     <= 32'h0;
            nbytes_q   <= 3'd0;
            iss_q      <= 3'd0;
            cap_q      <= 3'd0;
            wdata_q    <= 32'h0;
            fetch_q    <= 1'b0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            replay_q   <= 1'b0;
            asm_q      <= 32'h0;
            mem_a_q    <= 32'h0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'h0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nbytes_q   <= nbytes_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            wdata_q    <= wdata_d;
            fetch_q    <= fetch_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            replay_q   <= replay_d;
            asm_q      <= asm_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            assert (!(if_done_q && ls_done_q));
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model that returns data the
// cycle after the edge that latches the address.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0]  ram [0:262143];
    logic [31:0] a_lat = 32'h0;
    logic [31:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata),
        .flush          (flush)
    );

    always @(posedge clk_in) begin
        cyc   <= cyc + 1;
        a_lat <= mem_a;
        if (mem_wr && rdy_in && !rst_in) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_addr.push_back(mem_a);
            wr_data.push_back(mem_dout);
        end
    end
    assign mem_din = ram[a_lat[17:0]];

    task automatic wait_done(input bit want_if, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (want_if ? if_done : ls_done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_a got %h want 00000000", mem_a);
        end
        n_tests++;
        if (mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
            n_fail++; $display("FAIL reset_wr got wr=%b dout=%h want 0/00", mem_wr, mem_dout);
        end
        n_tests++;
        if (if_done !== 1'b0 || ls_done !== 1'b0 || if_data !== 32'h0 || ls_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp got %b %b %h %h want all zero",
                     if_done, ls_done, if_data, ls_rdata);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_fetch();
        int c0, at;
        bit ok, wr_seen;
        logic [31:0] seen [4];
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        @(negedge clk_in);
        if_addr = 32'h100; if_req = 1'b1; c0 = cyc + 1;
        wr_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            seen[i] = mem_a;
            wr_seen |= mem_wr;
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (seen[i] !== 32'h100 + i) begin
                n_fail++; $display("FAIL fetch_addr%0d got %h want %h", i, seen[i], 32'h100 + i);
            end
        end
        wait_done(1'b1, at, ok);
        if_req = 1'b0;
        n_tests++;
        if (wr_seen || !ok || at - c0 != 5) begin
            n_fail++; $display("FAIL fetch_latency got ok=%b lat=%0d wr=%b want 1/5/0",
                               ok, at - c0, wr_seen);
        end
        n_tests++;
        if (if_data !== 32'h00000513) begin
            n_fail++; $display("FAIL fetch_data got %h want 00000513", if_data);
        end
    endtask

    task automatic test_store();
        int c0, at;
        bit ok;
        wr_addr.delete(); wr_data.delete();
        @(negedge clk_in);
        ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h200; ls_wdata = 32'h0000BEEF; ls_req = 1'b1;
        c0 = cyc + 1;
        wait_done(1'b0, at, ok);
        ls_req = 1'b0; ls_we = 1'b0;
        n_tests++;
        if (!ok || at - c0 != 2) begin
            n_fail++; $display("FAIL store_latency got ok=%b lat=%0d want 1/2", ok, at - c0);
        end
        n_tests++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 32'h200 || wr_data[0] !== 8'hEF ||
            wr_addr[1] !== 32'h201 || wr_data[1] !== 8'hBE) begin
            n_fail++; $display("FAIL store_writes got %0d writes want (200,EF),(201,BE)",
                               wr_addr.size());
        end
        @(negedge clk_in);
        ls_size = 2'd2; ls_addr = 32'h200; ls_req = 1'b1; c0 = cyc + 1;
        wait_done(1'b0, at, ok);
        ls_req = 1'b0;
        n_tests++;
        if (!ok || at - c0 != 5 || ls_rdata !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL load_word got lat=%0d data=%h want 5/0000BEEF",
                               at - c0, ls_rdata);
        end
        @(negedge clk_in);
        ls_size = 2'd0; ls_addr = 32'h201; ls_req = 1'b1; c0 = cyc + 1;
        wait_done(1'b0, at, ok);
        ls_req = 1'b0;
        n_tests++;
        if (!ok || at - c0 != 2 || ls_rdata !== 32'h000000BE) begin
            n_fail++; $display("FAIL load_byte got lat=%0d data=%h want 2/000000BE",
                               at - c0, ls_rdata);
        end
    endtask

    task automatic test_contention();
        int c0, ls_at, if_at;
        bit got_ls, got_if, overlap;
        ram[18'h10] = 8'hA5;
        @(negedge clk_in);
        ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10; ls_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1; c0 = cyc + 1;
        got_ls = 1'b0; got_if = 1'b0; overlap = 1'b0; ls_at = 0; if_at = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_in);
            if (if_done && ls_done) overlap = 1'b1;
            if (ls_done && !got_ls) begin got_ls = 1'b1; ls_at = cyc; ls_req = 1'b0; end
            if (if_done && !got_if) begin got_if = 1'b1; if_at = cyc; if_req = 1'b0; end
            if (got_ls && got_if) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        n_tests++;
        if (!got_ls || ls_at - c0 != 2 || ls_rdata !== 32'h000000A5) begin
            n_fail++; $display("FAIL contention_ls got ok=%b lat=%0d data=%h want 1/2/000000A5",
                               got_ls, ls_at - c0, ls_rdata);
        end
        n_tests++;
        if (!got_if || if_at != ls_at + 6 || if_data !== 32'h00000513 || overlap) begin
            n_fail++; $display("FAIL contention_if got ok=%b gap=%0d data=%h ovl=%b want 1/6/513/0",
                               got_if, if_at - ls_at, if_data, overlap);
        end
    endtask

    task automatic test_io_backpressure();
        int c0, at;
        bit ok, early;
        wr_addr.delete(); wr_data.delete();
        @(negedge clk_in);
        io_buffer_full = 1'b1;
        ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h41; ls_req = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (mem_wr || ls_done) early = 1'b1;
        end
        n_tests++;
        if (early) begin
            n_fail++; $display("FAIL io_blocked got a write or done while full want none");
        end
        io_buffer_full = 1'b0; c0 = cyc + 1;
        wait_done(1'b0, at, ok);
        ls_req = 1'b0; ls_we = 1'b0;
        n_tests++;
        if (!ok || at - c0 != 1 || wr_addr.size() != 1 || wr_addr[0] !== 32'h30000 ||
            wr_data[0] !== 8'h41) begin
            n_fail++; $display("FAIL io_release got ok=%b lat=%0d writes=%0d want 1/1/1",
                               ok, at - c0, wr_addr.size());
        end
    endtask

    task automatic test_pause();
        int c0, at;
        bit ok, moved;
        ram[18'h104] = 8'h78; ram[18'h105] = 8'h56; ram[18'h106] = 8'h34; ram[18'h107] = 8'h12;
        @(negedge clk_in);
        if_addr = 32'h104; if_req = 1'b1; c0 = cyc + 1;
        repeat (2) @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h105) begin
            n_fail++; $display("FAIL pause_byte1 got %h want 00000105", mem_a);
        end
        rdy_in = 1'b0; moved = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            if (mem_a !== 32'h105 || if_done) moved = 1'b1;
        end
        rdy_in = 1'b1;
        n_tests++;
        if (moved) begin
            n_fail++; $display("FAIL pause_hold got a change while paused want held 00000105");
        end
        @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h104) begin
            n_fail++; $display("FAIL pause_replay got %h want 00000104", mem_a);
        end
        wait_done(1'b1, at, ok);
        if_req = 1'b0;
        n_tests++;
        if (!ok || at - c0 < 8 || at - c0 > 10 || if_data !== 32'h12345678) begin
            n_fail++; $display("FAIL pause_data got ok=%b lat=%0d data=%h want 8..10/12345678",
                               ok, at - c0, if_data);
        end
    endtask

    task automatic test_wrap();
        int c0, at;
        bit ok;
        ram[18'h3FFFF] = 8'h11; ram[18'h0] = 8'h22;
        @(negedge clk_in);
        ls_we = 1'b0; ls_size = 2'd1; ls_addr = 32'hFFFFFFFF; ls_req = 1'b1; c0 = cyc + 1;
        repeat (2) @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr got %h want 00000000", mem_a);
        end
        wait_done(1'b0, at, ok);
        ls_req = 1'b0;
        n_tests++;
        if (!ok || at - c0 != 3 || ls_rdata !== 32'h00002211) begin
            n_fail++; $display("FAIL wrap_data got lat=%0d data=%h want 3/00002211",
                               at - c0, ls_rdata);
        end
    endtask

    task automatic test_flush();
        int c1, ls_at;
        bit got_ls, stray;
        @(negedge clk_in);
        if_addr = 32'h100; if_req = 1'b1;
        repeat (2) @(negedge clk_in);
        flush = 1'b1;
        @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h0) begin
            n_fail++; $display("FAIL flush_idle got mem_a %h want 00000000", mem_a);
        end
        flush = 1'b0; if_req = 1'b0;
        ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h200; ls_req = 1'b1; c1 = cyc + 1;
        got_ls = 1'b0; stray = 1'b0; ls_at = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (if_done) stray = 1'b1;
            if (ls_done && !got_ls) begin got_ls = 1'b1; ls_at = cyc; ls_req = 1'b0; end
        end
        ls_req = 1'b0;
        n_tests++;
        if (stray || if_data !== 32'h12345678) begin
            n_fail++; $display("FAIL flush_no_done got stray=%b if_data=%h want 0/12345678",
                               stray, if_data);
        end
        n_tests++;
        if (!got_ls || ls_at - c1 != 2 || ls_rdata !== 32'h000000EF) begin
            n_fail++; $display("FAIL flush_load got ok=%b lat=%0d data=%h want 1/2/000000EF",
                               got_ls, ls_at - c1, ls_rdata);
        end
    endtask

    task automatic test_reset_mid_store();
        bit stray;
        @(negedge clk_in);
        ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'hCAFEF00D; ls_req = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        n_tests++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0 || ls_done !== 1'b0 ||
            ls_rdata !== 32'h0 || if_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_store got a=%h wr=%b dout=%h done=%b want zeros",
                               mem_a, mem_wr, mem_dout, ls_done);
        end
        rst_in = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            if (ls_done || mem_wr) stray = 1'b1;
        end
        n_tests++;
        if (stray) begin
            n_fail++; $display("FAIL rst_abandon got activity after reset want none");
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_io_backpressure();
        test_pause();
        test_wrap();
        test_flush();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
